// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: word width, special instruction
// encodings and the halt FSM state encoding.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_WORD  = 32'hF800_0000;
    localparam logic [WORD_W-1:0] HALT_WORD = 32'hFC00_0000;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

endpackage : mips_pkg

// File: rtl/instr_mem.sv
// Instruction memory: MEM_DEPTH x 32 words, combinational read port and a
// synchronous write port used by the debug loader.
module instr_mem
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    // NOTE: storage has no reset; program contents survive a pipeline reset
    // and a reset loop would prevent mapping onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : instr_mem

// File: rtl/instruction_fetch.sv
// IF stage: program counter, next-PC selection, instruction memory read and
// the HALT detection FSM that freezes fetch and emits NOPs until reset.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         ENABLE,
    input  logic                         I_IF_PC_WRITE,
    input  logic                         I_IF_BRANCH_TAKEN,
    input  logic [WORD_W-1:0]            I_IF_BRANCH_TARGET,
    input  logic                         I_IF_JUMP,
    input  logic [WORD_W-1:0]            I_IF_JUMP_TARGET,
    input  logic                         I_IF_MEM_WE,
    input  logic [$clog2(MEM_DEPTH)-1:0] I_IF_MEM_WADDR,
    input  logic [WORD_W-1:0]            I_IF_MEM_WDATA,
    output logic [WORD_W-1:0]            O_IF_INSTRUCTION,
    output logic [WORD_W-1:0]            O_IF_PC,
    output logic [WORD_W-1:0]            O_IF_PC_CURRENT,
    output logic                         O_IF_HALTED
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam logic [WORD_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] pc_next;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] fetched;
    logic [0:0]        state;
    logic              in_range;
    logic              redirect;
    logic              halt_fire;

    instr_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_instr_mem (
        .clk   (CLK),
        .we    (I_IF_MEM_WE),
        .waddr (I_IF_MEM_WADDR),
        .wdata (I_IF_MEM_WDATA),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (mem_rdata)
    );

    assign pc_plus4 = pc + 32'd4;
    assign in_range = (pc >> (ADDR_W + 2)) == '0;
    assign fetched  = in_range ? mem_rdata : NOP_WORD;
    assign redirect = I_IF_BRANCH_TAKEN || I_IF_JUMP;

    // Halt only on a cycle where the HALT word would really be consumed downstream.
    assign halt_fire = ENABLE && (state == ST_RUN) && I_IF_PC_WRITE
                       && !redirect && (fetched == HALT_WORD);

    // NOTE: pc_next gets a default first so every path assigns it and no
    // latch is inferred.
    always_comb begin
        pc_next = pc;
        if (!ENABLE || state == ST_HALTED || halt_fire) begin
            pc_next = pc;
        end else if (I_IF_BRANCH_TAKEN) begin
            pc_next = I_IF_BRANCH_TARGET & ALIGN_MASK;
        end else if (I_IF_JUMP) begin
            pc_next = I_IF_JUMP_TARGET & ALIGN_MASK;
        end else if (I_IF_PC_WRITE) begin
            pc_next = pc_plus4;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc    <= RESET_PC & ALIGN_MASK;
            state <= ST_RUN;
        end else begin
            pc <= pc_next;
            if (halt_fire) begin
                state <= ST_HALTED;
            end
        end
    end

    assign O_IF_INSTRUCTION = (state == ST_HALTED) ? NOP_WORD : fetched;
    assign O_IF_PC          = pc_plus4;
    assign O_IF_PC_CURRENT  = pc;
    assign O_IF_HALTED      = (state == ST_HALTED);

endmodule : instruction_fetch
